// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer.
// Contents:
//   seq_state_e  - sequencer state encoding (IDLE, HOLD, RELEASE, DONE)
//   DEF_*        - default parameter values
//   cnt_width()  - width of the hold/stagger counter
package rst_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2,
    DONE    = 2'd3
  } seq_state_e;

  localparam int DEF_NUM_CH   = 4;
  localparam int DEF_PULSE_W  = 16;
  localparam int DEF_STAGGER  = 8;
  localparam int DEF_WDOG_CYC = 1000000;

  // The counter must reach the larger of the two intervals without wrapping.
  function automatic int cnt_width(input int pulse_w, input int stagger);
    int max_v;
    max_v = (pulse_w > stagger) ? pulse_w : stagger;
    return $clog2(max_v + 1);
  endfunction

endpackage

// File: rtl/rst_seq_wdog.sv
// Idle watchdog for the reset sequencer.
// Ports:
//   clk, rst   - system clock, asynchronous active-high reset
//   run        - high while the sequencer is idle; the counter only runs then
//   kick       - clears the counter
//   expire     - high in the cycle whose closing edge reaches WDOG_CYC idle cycles
//   wdog_trip  - registered one-cycle pulse, aligned with the sequence restart
module rst_seq_wdog
  import rst_seq_pkg::*;
#(
  parameter int WDOG_CYC = DEF_WDOG_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic kick,
  output logic expire,
  output logic wdog_trip
);

  localparam int WW = $clog2(WDOG_CYC + 1);
  localparam logic [WW-1:0] LAST_C = WW'(WDOG_CYC - 1);
  localparam logic [WW-1:0] ONE_C  = WW'(1'b1);

  logic [WW-1:0] cnt_r;

  // The edge that would make the count reach WDOG_CYC is the expiry edge.
  assign expire = run && !kick && (cnt_r == LAST_C);

  // Idle-cycle counter; cleared outside IDLE, on kick and on expiry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {WW{1'b0}};
    end else if (!run || kick || expire) begin
      cnt_r <= {WW{1'b0}};
    end else begin
      cnt_r <= cnt_r + ONE_C;
    end
  end

  // Registered trip pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_trip <= 1'b0;
    end else begin
      wdog_trip <= expire;
    end
  end

endmodule

// File: rtl/rst_sequencer.sv
// Multi-channel staggered reset sequencer.
// Holds all channels in reset after rst, then releases them lowest index
// first, PULSE_W cycles after start and STAGGER cycles apart. A software
// request re-runs the sequence on a subset of channels.
// Ports:
//   clk, rst   - system clock, asynchronous active-high reset
//   sw_req     - single-cycle software reset request
//   ch_mask    - channels to reset, sampled with sw_req
//   kick       - watchdog kick (ignored unless RST_SEQ_WDOG_EN is defined)
//   rst_out    - per-channel active-high reset
//   busy       - sequence in progress
//   done       - one-cycle pulse on sequence completion
//   ovr        - one-cycle pulse when a request arrives outside IDLE
//   wdog_trip  - one-cycle pulse on watchdog expiry (0 unless RST_SEQ_WDOG_EN)
// Build option: define RST_SEQ_WDOG_EN to include the idle watchdog.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int PULSE_W  = DEF_PULSE_W,
  parameter int STAGGER  = DEF_STAGGER,
  parameter int WDOG_CYC = DEF_WDOG_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sw_req,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              kick,
  output logic [NUM_CH-1:0] rst_out,
  output logic              busy,
  output logic              done,
  output logic              ovr,
  output logic              wdog_trip
);

  localparam int CW = cnt_width(PULSE_W, STAGGER);
  localparam logic [CW-1:0]     PULSE_C   = CW'(PULSE_W);
  localparam logic [CW-1:0]     STAGGER_C = CW'(STAGGER);
  localparam logic [CW-1:0]     ONE_CNT   = CW'(1'b1);
  localparam logic [CW-1:0]     ZERO_CNT  = {CW{1'b0}};
  localparam logic [NUM_CH-1:0] ONE_CH    = NUM_CH'(1'b1);
  localparam logic [NUM_CH-1:0] ALL_CH    = {NUM_CH{1'b1}};
  localparam logic [NUM_CH-1:0] ZERO_CH   = {NUM_CH{1'b0}};

  seq_state_e        state_r;
  logic [CW-1:0]     cnt_r;
  logic [NUM_CH-1:0] active_r;
  logic [NUM_CH-1:0] lowest_s;
  logic              wdog_expire_s;

  // Isolate the lowest channel still waiting for release.
  assign lowest_s = active_r & (~active_r + ONE_CH);

`ifdef RST_SEQ_WDOG_EN
  logic idle_s;
  assign idle_s = (state_r == IDLE);

  rst_seq_wdog #(
    .WDOG_CYC(WDOG_CYC)
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .run      (idle_s),
    .kick     (kick),
    .expire   (wdog_expire_s),
    .wdog_trip(wdog_trip)
  );
`else
  logic unused_s;
  assign unused_s      = kick ^ (WDOG_CYC < 1);
  assign wdog_expire_s = 1'b0;
  assign wdog_trip     = 1'b0;
`endif

  // Sequencer FSM with registered outputs.
  // cnt_r holds the number of edges since the outputs last changed. After
  // rst it starts at 0 because the first edge with rst low is itself the
  // first counted edge; a software request loads 1 because the request edge
  // already drove the masked outputs high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= HOLD;
      cnt_r    <= ZERO_CNT;
      active_r <= ALL_CH;
      rst_out  <= ALL_CH;
      busy     <= 1'b1;
      done     <= 1'b0;
      ovr      <= 1'b0;
    end else if (wdog_expire_s) begin
      // Watchdog restart behaves exactly like rst; it also beats sw_req.
      state_r  <= HOLD;
      cnt_r    <= ZERO_CNT;
      active_r <= ALL_CH;
      rst_out  <= ALL_CH;
      busy     <= 1'b1;
      done     <= 1'b0;
      ovr      <= 1'b0;
    end else begin
      done <= 1'b0;
      ovr  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (sw_req && (ch_mask != ZERO_CH)) begin
            state_r  <= HOLD;
            cnt_r    <= ONE_CNT;
            active_r <= ch_mask;
            rst_out  <= rst_out | ch_mask;
            busy     <= 1'b1;
          end else begin
            cnt_r <= ZERO_CNT;
          end
        end
        HOLD: begin
          ovr <= sw_req;
          if (cnt_r == PULSE_C) begin
            state_r  <= RELEASE;
            cnt_r    <= ONE_CNT;
            active_r <= active_r & ~lowest_s;
            rst_out  <= rst_out & ~lowest_s;
          end else begin
            cnt_r <= cnt_r + ONE_CNT;
          end
        end
        RELEASE: begin
          ovr <= sw_req;
          if (active_r == ZERO_CH) begin
            state_r <= DONE;
            cnt_r   <= ZERO_CNT;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else if (cnt_r == STAGGER_C) begin
            cnt_r    <= ONE_CNT;
            active_r <= active_r & ~lowest_s;
            rst_out  <= rst_out & ~lowest_s;
          end else begin
            cnt_r <= cnt_r + ONE_CNT;
          end
        end
        DONE: begin
          ovr     <= sw_req;
          state_r <= IDLE;
          cnt_r   <= ZERO_CNT;
        end
        default: begin
          state_r  <= IDLE;
          cnt_r    <= ZERO_CNT;
          active_r <= ZERO_CH;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rst_sequencer.sv
module tb_rst_sequencer;

  localparam int N = 4;
  localparam int P = 16;
  localparam int S = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic         rst, sw_req, kick;
  logic [N-1:0] ch_mask, rst_out;
  logic         busy, done, ovr, wdog_trip;

  rst_sequencer #(.NUM_CH(N), .PULSE_W(P), .STAGGER(S), .WDOG_CYC(100)) dut (
    .clk(clk), .rst(rst), .sw_req(sw_req), .ch_mask(ch_mask), .kick(kick),
    .rst_out(rst_out), .busy(busy), .done(done), .ovr(ovr), .wdog_trip(wdog_trip)
  );

  // Minimal-parameter instance
  logic       rst1, sw1, busy1, done1, ovr1, trip1;
  logic [0:0] mask1, out1;

  rst_sequencer #(.NUM_CH(1), .PULSE_W(1), .STAGGER(1), .WDOG_CYC(100)) dut1 (
    .clk(clk), .rst(rst1), .sw_req(sw1), .ch_mask(mask1), .kick(1'b0),
    .rst_out(out1), .busy(busy1), .done(done1), .ovr(ovr1), .wdog_trip(trip1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Reference model: each sequence is described by per-channel release edges
  int t;
  int rel_edge [N];
  int done_edge;
  int idle_from;

  function automatic void start_seq(input int e, input logic [N-1:0] mask);
    int j;
    j = 0;
    for (int c = 0; c < N; c++) begin
      if (mask[c]) begin
        rel_edge[c] = e + P + j * S;
        j++;
      end else begin
        rel_edge[c] = -1;
      end
    end
    done_edge = e + P + (j - 1) * S + 1;
    idle_from = done_edge + 2;
  endfunction

  function automatic void model_reset();
    t = 0;
    start_seq(0, {N{1'b1}});
  endfunction

  // One clock edge on the main instance, checked against the model.
  task automatic step(input logic sw, input logic [N-1:0] mask);
    logic         exp_ovr;
    logic [N-1:0] exp_out;
    @(negedge clk);
    sw_req  = sw;
    ch_mask = mask;
    @(posedge clk);
    exp_ovr = sw && (t < idle_from);
    if (sw && (t >= idle_from) && (mask != '0)) start_seq(t, mask);
    for (int c = 0; c < N; c++) exp_out[c] = (t < rel_edge[c]);
    #1;
    check($sformatf("model rst_out @%0d", t), 32'(rst_out), 32'(exp_out));
    check($sformatf("model busy @%0d", t), 32'(busy), 32'(t < done_edge));
    check($sformatf("model done @%0d", t), 32'(done), 32'(t == done_edge));
    check($sformatf("model ovr @%0d", t), 32'(ovr), 32'(exp_ovr));
    t++;
  endtask

  task automatic check_in_reset(input string tag);
    check({tag, " rst_out"}, 32'(rst_out), 32'(4'b1111));
    check({tag, " busy"}, 32'(busy), 32'(1'b1));
    check({tag, " done"}, 32'(done), 32'(1'b0));
    check({tag, " ovr"}, 32'(ovr), 32'(1'b0));
  endtask

  typedef struct {
    int         edge_n;
    logic       sw;
    logic [3:0] mask;
    logic [3:0] out;
    logic       busy;
    logic       done;
    logic       ovr;
  } vec_t;

  vec_t tbl[$];
  vec_t tbl1[$];

  function automatic void add(ref vec_t q[$], input int e, input logic sw, input logic [3:0] m,
                              input logic [3:0] o, input logic b, input logic d, input logic v);
    vec_t x;
    x.edge_n = e; x.sw = sw; x.mask = m; x.out = o; x.busy = b; x.done = d; x.ovr = v;
    q.push_back(x);
  endfunction

  initial begin
    // Power-on, masked request, overrun and zero-mask vectors (defaults)
    add(tbl,   0, 1'b0, 4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0);
    add(tbl,  15, 1'b0, 4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0);
    add(tbl,  16, 1'b0, 4'b0000, 4'b1110, 1'b1, 1'b0, 1'b0);
    add(tbl,  23, 1'b0, 4'b0000, 4'b1110, 1'b1, 1'b0, 1'b0);
    add(tbl,  24, 1'b0, 4'b0000, 4'b1100, 1'b1, 1'b0, 1'b0);
    add(tbl,  32, 1'b0, 4'b0000, 4'b1000, 1'b1, 1'b0, 1'b0);
    add(tbl,  40, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
    add(tbl,  41, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
    add(tbl,  42, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    add(tbl,  43, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    add(tbl, 100, 1'b1, 4'b0110, 4'b0110, 1'b1, 1'b0, 1'b0);
    add(tbl, 110, 1'b1, 4'b1111, 4'b0110, 1'b1, 1'b0, 1'b1);
    add(tbl, 111, 1'b0, 4'b0000, 4'b0110, 1'b1, 1'b0, 1'b0);
    add(tbl, 115, 1'b0, 4'b0000, 4'b0110, 1'b1, 1'b0, 1'b0);
    add(tbl, 116, 1'b0, 4'b0000, 4'b0100, 1'b1, 1'b0, 1'b0);
    add(tbl, 123, 1'b0, 4'b0000, 4'b0100, 1'b1, 1'b0, 1'b0);
    add(tbl, 124, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
    add(tbl, 125, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
    add(tbl, 126, 1'b1, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1);
    add(tbl, 127, 1'b1, 4'b1000, 4'b1000, 1'b1, 1'b0, 1'b0);
    add(tbl, 142, 1'b0, 4'b0000, 4'b1000, 1'b1, 1'b0, 1'b0);
    add(tbl, 143, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
    add(tbl, 144, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);

    // NUM_CH=1, PULSE_W=1, STAGGER=1: consecutive edges 0..7
    add(tbl1, 0, 1'b0, 4'b0000, 4'b0001, 1'b1, 1'b0, 1'b0);
    add(tbl1, 1, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
    add(tbl1, 2, 1'b1, 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b1);
    add(tbl1, 3, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    add(tbl1, 4, 1'b1, 4'b0001, 4'b0001, 1'b1, 1'b0, 1'b0);
    add(tbl1, 5, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
    add(tbl1, 6, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
    add(tbl1, 7, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);

    rst = 1'b1; rst1 = 1'b1; sw_req = 1'b0; ch_mask = '0; kick = 1'b0;
    sw1 = 1'b0; mask1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_in_reset("reset");
    check("reset wdog_trip", 32'(wdog_trip), 32'(1'b0));
    check("reset1 rst_out", 32'(out1), 32'(1'b1));
    check("reset1 busy", 32'(busy1), 32'(1'b1));

    // Minimal-parameter instance
    #1 rst1 = 1'b0;
    for (int i = 0; i < tbl1.size(); i++) begin
      @(negedge clk);
      sw1   = tbl1[i].sw;
      mask1 = tbl1[i].mask[0];
      @(posedge clk);
      #1;
      check($sformatf("p1 rst_out @%0d", i), 32'(out1), 32'(tbl1[i].out[0]));
      check($sformatf("p1 busy @%0d", i), 32'(busy1), 32'(tbl1[i].busy));
      check($sformatf("p1 done @%0d", i), 32'(done1), 32'(tbl1[i].done));
      check($sformatf("p1 ovr @%0d", i), 32'(ovr1), 32'(tbl1[i].ovr));
    end
    sw1 = 1'b0;

    // Main instance: directed table
    #1 rst = 1'b0;
    model_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      while (t < tbl[i].edge_n) step(1'b0, '0);
      step(tbl[i].sw, tbl[i].mask);
      check($sformatf("tbl rst_out @%0d", tbl[i].edge_n), 32'(rst_out), 32'(tbl[i].out));
      check($sformatf("tbl busy @%0d", tbl[i].edge_n), 32'(busy), 32'(tbl[i].busy));
      check($sformatf("tbl done @%0d", tbl[i].edge_n), 32'(done), 32'(tbl[i].done));
      check($sformatf("tbl ovr @%0d", tbl[i].edge_n), 32'(ovr), 32'(tbl[i].ovr));
    end

    // Reset in the middle of the power-on sequence
    #2 sw_req = 1'b0; rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
    repeat (21) step(1'b0, '0);
    check("pre-reset rst_out @20", 32'(rst_out), 32'(4'b1110));
    #2 rst = 1'b1;
    #1;
    check_in_reset("async reset");
    @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
    repeat (17) step(1'b0, '0);
    check("restart rst_out @16", 32'(rst_out), 32'(4'b1110));
    repeat (30) step(1'b0, '0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        #2 sw_req = 1'b0; rst = 1'b1;
        #1;
        check_in_reset("random reset");
        @(posedge clk);
        #2 rst = 1'b0;
        model_reset();
      end
      step(($urandom_range(0, 11) == 0), N'($urandom_range(0, 15)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rst_sequencer.md
# rst_sequencer

Parametrised multi-channel reset sequencer for the oscilloscope FPGA. It holds every downstream domain (MCU bus interface, sample capture, LCD timing, LED) in reset after power-up, then releases the domains one at a time in a fixed, staggered order. The MCU can request a masked re-reset of selected channels at runtime. It sits directly under `top`, between the board reset input and all other blocks.

## Interface
Parameters:
- `NUM_CH`, default 4: number of reset outputs; legal range 1..16.
- `PULSE_W`, default 16: cycles that asserted channels are held before the first release; minimum 1.
- `STAGGER`, default 8: cycles between successive channel releases; minimum 1.
- `WDOG_CYC`, default 1000000: watchdog timeout in cycles; used only with `RST_SEQ_WDOG_EN`.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `sw_req`  in  1  single-cycle software reset request.
- `ch_mask`  in  NUM_CH  channels to reset; sampled together with `sw_req`.
- `kick`  in  1  watchdog kick pulse.
- `rst_out`  out  NUM_CH  per-channel reset, active-high.
- `busy`  out  1  high while a sequence is in progress.
- `done`  out  1  one-cycle pulse when a sequence completes.
- `ovr`  out  1  one-cycle pulse when a request is dropped.
- `wdog_trip`  out  1  one-cycle pulse when the watchdog fires.

## Operation
- State machine: IDLE → HOLD → RELEASE → DONE → IDLE.
- While `rst` is high:
  - `rst_out` = all ones, `busy` = 1.
  - `done`, `ovr` and `wdog_trip` = 0.
  - State is HOLD, counter = 0, active mask = all ones.
- HOLD: counts `PULSE_W` cycles, then moves to RELEASE.
- RELEASE: clears the lowest-index asserted channel in the active mask. Each further asserted channel is cleared `STAGGER` cycles after the previous one. Channels outside the mask are never touched.
- DONE: lasts one cycle, during which `done` = 1 and `busy` = 0. Then the block returns to IDLE.
- IDLE, `sw_req` = 1 with nonzero `ch_mask`: the masked `rst_out` bits go high at that edge, `busy` = 1, state moves to HOLD.
- IDLE, `sw_req` = 1 with `ch_mask` = 0: no effect, and no `ovr`.
- `sw_req` = 1 while not in IDLE (HOLD, RELEASE or DONE): request is dropped and `ovr` pulses for one cycle. The running sequence is unaffected.
- Counter width is `$clog2(max(PULSE_W,STAGGER)+1)`. The counter clears at every release and at every state entry, so it never wraps.
- Assertion of `rst` mid-sequence overrides everything and restarts the full all-channel sequence.

## Timing
Edge 0 is the first rising edge of `clk` with `rst` low.
- Channel k of the full sequence releases at edge `PULSE_W + k*STAGGER`.
- `done` is high for the cycle after the edge `PULSE_W + (NUM_CH-1)*STAGGER + 1`.
- Software request sampled at edge e, with m masked channels:
  - masked outputs high from edge e;
  - j-th masked channel (j = 0..m-1) releases at `e + PULSE_W + j*STAGGER`;
  - `done` at `e + PULSE_W + (m-1)*STAGGER + 1`.
- All outputs are registered; there is no combinational path from inputs to outputs.
- A new `sw_req` is accepted from the cycle after `done`, when the state is IDLE again.

## Configuration
- `RST_SEQ_WDOG_EN` defined:
  - A `WDOG_CYC` counter runs only in IDLE.
  - `kick` = 1 clears the counter.
  - Reaching `WDOG_CYC` pulses `wdog_trip` and starts the full all-channel sequence, exactly as after `rst`.
  - If `sw_req` and expiry occur in the same cycle, the watchdog wins and `ovr` stays 0.
- Not defined: `kick` is ignored, `wdog_trip` is tied 0, and the watchdog counter is not synthesised.

## Structure
- `rst_seq_pkg` holds:
  - the state enum (IDLE, HOLD, RELEASE, DONE);
  - default parameter constants;
  - a width helper function for the counter.
- Sub-module `rst_seq_wdog` contains the watchdog counter and the `wdog_trip` generator. It is instantiated only under `RST_SEQ_WDOG_EN`.

## Test plan
All scenarios use defaults unless stated.
- Power-on: hold `rst` for 5 cycles, then release → `rst_out` = 4'b1111 until edge 16; then 4'b1110 @16, 4'b1100 @24, 4'b1000 @32, 4'b0000 @40; `done` high for the cycle after edge 41.
- Masked request: `sw_req` with `ch_mask` = 4'b0110 at edge 100 → `rst_out` = 4'b0110 @100, 4'b0100 @116, 4'b0000 @124; `done` after edge 125; channels 0 and 3 stay low throughout.
- Overrun: `sw_req` at edge 110 during the previous sequence → `ovr` pulses once, release times unchanged; zero-mask `sw_req` in IDLE → no `ovr`, no `busy`.
- Reset mid-sequence: assert `rst` at edge 20 of the power-on sequence → `rst_out` = 4'b1111 asynchronously; full sequence restarts after release.
- Watchdog (`RST_SEQ_WDOG_EN`, `WDOG_CYC` = 100): no `kick` → `wdog_trip` 100 cycles after entering IDLE, then the full sequence; `kick` every 50 cycles → no trip.
- Edge parameters: `NUM_CH` = 1, `PULSE_W` = 1, `STAGGER` = 1 → `rst_out` released at edge 1, `done` after edge 2.
